// File: rtl/dm_reader.sv
// dm_reader: load unit front-end for a word-wide data memory.
// It accepts one load request at a time and classifies it as legal or illegal.
// A legal request issues a single read strobe and waits RD_LATENCY edges.
// The selected byte, half or word is then sign- or zero-extended.
// The result is held until the consumer takes it.
module dm_reader #(
    parameter int RD_LATENCY = 1
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] ReqAddr,
    input  logic [2:0]  ldCon,
    output logic        mem_rd_en,
    output logic [10:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    typedef enum logic [1:0] {IDLE, READ, WAIT, RESP} state_t;

    // Edge number (READ edge = 1) at which the returning word is captured
    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    state_t      state;
    logic [1:0]  lat_lane;
    logic [2:0]  lat_ld;
    logic [2:0]  wait_cnt;
    logic        illegal;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] ext_data;
    logic        addr_unused;

    // Upper address bits play no part in decoding or addressing
    assign addr_unused = ^ReqAddr[31:16];

    // Classify the request presented on the inputs as legal or illegal
    always_comb begin
        illegal = 1'b0;
        if (ldCon > 3'd4)
            illegal = 1'b1;
        if (ReqAddr[15:13] != 3'd0)
            illegal = 1'b1;
        if ((ldCon == 3'd0) && (ReqAddr[1:0] != 2'd0))
            illegal = 1'b1;
        if (((ldCon == 3'd1) || (ldCon == 3'd2)) && ReqAddr[0])
            illegal = 1'b1;
    end

    // Pick the addressed lane of the returning word and extend it per load type
    always_comb begin
        case (lat_lane)
            2'd0:    sel_byte = mem_rdata[7:0];
            2'd1:    sel_byte = mem_rdata[15:8];
            2'd2:    sel_byte = mem_rdata[23:16];
            default: sel_byte = mem_rdata[31:24];
        endcase
        sel_half = lat_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lat_ld)
            3'd0:    ext_data = mem_rdata;
            3'd1:    ext_data = {{16{sel_half[15]}}, sel_half};
            3'd2:    ext_data = {16'd0, sel_half};
            3'd3:    ext_data = {{24{sel_byte[7]}}, sel_byte};
            3'd4:    ext_data = {24'd0, sel_byte};
            default: ext_data = 32'd0;
        endcase
    end

    // Request/response sequencer with all outputs registered
    always_ff @(posedge Clk) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            mem_rd_en <= 1'b0;
            mem_addr  <= 11'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_err   <= 1'b0;
            lat_lane  <= 2'd0;
            lat_ld    <= 3'd0;
            wait_cnt  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_lane  <= ReqAddr[1:0];
                        lat_ld    <= ldCon;
                        req_ready <= 1'b0;
                        if (illegal) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= 32'd0;
                        end else begin
                            state     <= READ;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= ReqAddr[12:2];
                        end
                    end
                end
                READ: begin
                    mem_rd_en <= 1'b0;
                    if (LAT <= 3'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= ext_data;
                        rsp_err   <= 1'b0;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= 3'd2;
                    end
                end
                WAIT: begin
                    if (wait_cnt == LAT) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= ext_data;
                        rsp_err   <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_data  <= 32'd0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_reader.sv
// tb_dm_reader: drives two dm_reader instances (RD_LATENCY 1 and 3) with the
// same request stream and compares each against a behavioural load model.
module tb_dm_reader;

    logic        Clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        rsp_ready;
    logic [31:0] ReqAddr;
    logic [2:0]  ldCon;

    logic        req_ready_1, mem_rd_en_1, rsp_valid_1, rsp_err_1;
    logic [10:0] mem_addr_1;
    logic [31:0] mem_rdata_1, rsp_data_1;
    logic        req_ready_3, mem_rd_en_3, rsp_valid_3, rsp_err_3;
    logic [10:0] mem_addr_3;
    logic [31:0] mem_rdata_3, rsp_data_3;

    logic [31:0] mem [0:2047];
    logic [31:0] junk = 32'd0;
    logic [1:0]  pipe_v = 2'b00;
    logic [10:0] pipe_a0 = 11'd0;
    logic [10:0] pipe_a1 = 11'd0;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        int          first1;
        int          first3;
        logic [31:0] data1;
        logic [31:0] data3;
        logic        err1;
        logic        err3;
        int          rd1;
        int          rd3;
        bit          proto_bad;
    } obs_t;

    localparam logic [46:0] RESET_VEC = {1'b1, 46'd0};

    always #5 Clk = ~Clk;

    dm_reader #(.RD_LATENCY(1)) dut1 (
        .Clk(Clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_1),
        .ReqAddr(ReqAddr), .ldCon(ldCon), .mem_rd_en(mem_rd_en_1), .mem_addr(mem_addr_1),
        .mem_rdata(mem_rdata_1), .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_1), .rsp_err(rsp_err_1)
    );

    dm_reader #(.RD_LATENCY(3)) dut3 (
        .Clk(Clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_3),
        .ReqAddr(ReqAddr), .ldCon(ldCon), .mem_rd_en(mem_rd_en_3), .mem_addr(mem_addr_3),
        .mem_rdata(mem_rdata_3), .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_3), .rsp_err(rsp_err_3)
    );

    // Memory data is only meaningful on the capture edge; junk otherwise
    always @(negedge Clk) junk <= $urandom;

    // Latency-1 memory answers in the same cycle the strobe is high
    assign mem_rdata_1 = mem_rd_en_1 ? mem[mem_addr_1] : junk;

    // Latency-3 memory: two register stages after the strobe is sampled
    always @(posedge Clk) begin
        pipe_v  <= {pipe_v[0], mem_rd_en_3};
        pipe_a0 <= mem_addr_3;
        pipe_a1 <= pipe_a0;
    end
    assign mem_rdata_3 = pipe_v[1] ? mem[pipe_a1] : junk;

    // Reference load semantics from plain arithmetic: {err, data}
    function automatic logic [32:0] model(input logic [31:0] addr, input logic [2:0] ld,
                                          input logic [31:0] word);
        int unsigned b;
        int unsigned h;
        logic [31:0] r;
        bit          err;
        err = (ld > 3'd4) || (addr[15:13] != 3'd0) ||
              (ld == 3'd0 && addr % 4 != 0) ||
              ((ld == 3'd1 || ld == 3'd2) && addr % 2 != 0);
        b = (word >> (8 * (addr % 4))) % 256;
        h = (word >> (16 * ((addr / 2) % 2))) % 65536;
        case (ld)
            3'd0:    r = word;
            3'd1:    r = (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd2:    r = h;
            3'd3:    r = (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd4:    r = b;
            default: r = 32'd0;
        endcase
        if (err) r = 32'd0;
        return {err, r};
    endfunction

    // Issue one request with rsp_ready high and record what both DUTs do
    task automatic run_txn(input logic [31:0] addr, input logic [2:0] ld, output obs_t o);
        o.first1 = 0; o.first3 = 0; o.data1 = 32'd0; o.data3 = 32'd0;
        o.err1 = 1'b0; o.err3 = 1'b0; o.rd1 = 0; o.rd3 = 0; o.proto_bad = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        ReqAddr   = addr;
        ldCon     = ld;
        if (!(req_ready_1 === 1'b1 && req_ready_3 === 1'b1)) o.proto_bad = 1'b1;
        @(posedge Clk); #1;
        req_valid = 1'b0;
        ReqAddr   = $urandom;
        ldCon     = 3'($urandom_range(0, 7));
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (rsp_valid_1 === 1'b1 && o.first1 == 0) begin
                o.first1 = cyc; o.data1 = rsp_data_1; o.err1 = rsp_err_1;
            end
            if (rsp_valid_3 === 1'b1 && o.first3 == 0) begin
                o.first3 = cyc; o.data3 = rsp_data_3; o.err3 = rsp_err_3;
            end
            if (mem_rd_en_1 === 1'b1) begin
                o.rd1++;
                if (mem_addr_1 !== addr[12:2]) o.proto_bad = 1'b1;
            end
            if (mem_rd_en_3 === 1'b1) begin
                o.rd3++;
                if (mem_addr_3 !== addr[12:2]) o.proto_bad = 1'b1;
            end
            if ((req_ready_1 && rsp_valid_1) || (req_ready_3 && rsp_valid_3)) o.proto_bad = 1'b1;
            if (rsp_valid_1 !== 1'b1 && (rsp_data_1 !== 32'd0 || rsp_err_1 !== 1'b0)) o.proto_bad = 1'b1;
            if (rsp_valid_3 !== 1'b1 && (rsp_data_3 !== 32'd0 || rsp_err_3 !== 1'b0)) o.proto_bad = 1'b1;
            @(posedge Clk); #1;
        end
    endtask

    // Outputs settle to their reset values even with a request pending
    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b1; ReqAddr = 32'h10; ldCon = 3'd0; rsp_ready = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        req_valid = 1'b0; rsp_ready = 1'b1;
        total_cnt++;
        if ({req_ready_1, mem_rd_en_1, mem_addr_1, rsp_valid_1, rsp_data_1, rsp_err_1} !== RESET_VEC)
            $display("FAIL reset_lat1: got %h expected %h",
                     {req_ready_1, mem_rd_en_1, mem_addr_1, rsp_valid_1, rsp_data_1, rsp_err_1}, RESET_VEC);
        else pass_cnt++;
        total_cnt++;
        if ({req_ready_3, mem_rd_en_3, mem_addr_3, rsp_valid_3, rsp_data_3, rsp_err_3} !== RESET_VEC)
            $display("FAIL reset_lat3: got %h expected %h",
                     {req_ready_3, mem_rd_en_3, mem_addr_3, rsp_valid_3, rsp_data_3, rsp_err_3}, RESET_VEC);
        else pass_cnt++;
        reset = 1'b0;
        @(posedge Clk); #1;
    endtask

    // Known word 0x8081F2F3 at 0x10: each lane and extension type
    task automatic test_loads();
        logic [31:0] t_addr [0:6];
        logic [2:0]  t_ld   [0:6];
        logic [31:0] t_exp  [0:6];
        obs_t o;
        t_addr = '{32'h10, 32'h12, 32'h10, 32'h11, 32'h13, 32'h10, 32'h10};
        t_ld   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4};
        t_exp  = '{32'h8081F2F3, 32'hFFFF8081, 32'h0000F2F3, 32'hFFFFFFF2,
                   32'h00000080, 32'hFFFFFFF3, 32'h000000F3};
        for (int i = 0; i < 7; i++) begin
            run_txn(t_addr[i], t_ld[i], o);
            total_cnt++;
            if (o.first1 != 2 || o.first3 != 4)
                $display("FAIL load%0d latency: got %0d/%0d expected 2/4", i, o.first1, o.first3);
            else pass_cnt++;
            total_cnt++;
            if ({o.err1, o.data1} !== {1'b0, t_exp[i]})
                $display("FAIL load%0d data_lat1: got %0b/%h expected 0/%h", i, o.err1, o.data1, t_exp[i]);
            else pass_cnt++;
            total_cnt++;
            if ({o.err3, o.data3} !== {1'b0, t_exp[i]})
                $display("FAIL load%0d data_lat3: got %0b/%h expected 0/%h", i, o.err3, o.data3, t_exp[i]);
            else pass_cnt++;
            total_cnt++;
            if (o.rd1 != 1 || o.rd3 != 1)
                $display("FAIL load%0d strobes: got %0d/%0d expected 1/1", i, o.rd1, o.rd3);
            else pass_cnt++;
            total_cnt++;
            if (o.proto_bad)
                $display("FAIL load%0d protocol: got violation expected none", i);
            else pass_cnt++;
        end
    endtask

    // Misaligned, out-of-range and undefined-type requests answer with an error
    task automatic test_illegal();
        logic [31:0] t_addr [0:3];
        logic [2:0]  t_ld   [0:3];
        obs_t o;
        t_addr = '{32'h12, 32'h11, 32'h10, 32'h2000};
        t_ld   = '{3'd0, 3'd1, 3'd6, 3'd0};
        for (int i = 0; i < 4; i++) begin
            run_txn(t_addr[i], t_ld[i], o);
            total_cnt++;
            if (o.first1 != 1 || o.first3 != 1)
                $display("FAIL illegal%0d latency: got %0d/%0d expected 1/1", i, o.first1, o.first3);
            else pass_cnt++;
            total_cnt++;
            if ({o.err1, o.data1} !== {1'b1, 32'd0})
                $display("FAIL illegal%0d resp_lat1: got %0b/%h expected 1/0", i, o.err1, o.data1);
            else pass_cnt++;
            total_cnt++;
            if ({o.err3, o.data3} !== {1'b1, 32'd0})
                $display("FAIL illegal%0d resp_lat3: got %0b/%h expected 1/0", i, o.err3, o.data3);
            else pass_cnt++;
            total_cnt++;
            if (o.rd1 != 0 || o.rd3 != 0)
                $display("FAIL illegal%0d strobes: got %0d/%0d expected 0/0", i, o.rd1, o.rd3);
            else pass_cnt++;
            total_cnt++;
            if (o.proto_bad)
                $display("FAIL illegal%0d protocol: got violation expected none", i);
            else pass_cnt++;
        end
    endtask

    // Random addresses and load types against the reference model
    task automatic test_random();
        obs_t        o;
        logic [31:0] addr;
        logic [2:0]  ld;
        logic [32:0] exp;
        int          lat1;
        int          lat3;
        int          rds;
        for (int i = 0; i < 30; i++) begin
            addr = {16'($urandom), ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0, 13'($urandom)};
            ld   = 3'($urandom_range(0, 7));
            exp  = model(addr, ld, mem[addr[12:2]]);
            lat1 = exp[32] ? 1 : 2;
            lat3 = exp[32] ? 1 : 4;
            rds  = exp[32] ? 0 : 1;
            run_txn(addr, ld, o);
            total_cnt++;
            if (o.first1 != lat1 || o.first3 != lat3)
                $display("FAIL rand%0d latency: got %0d/%0d expected %0d/%0d", i, o.first1, o.first3, lat1, lat3);
            else pass_cnt++;
            total_cnt++;
            if ({o.err1, o.data1} !== exp)
                $display("FAIL rand%0d data_lat1 addr=%h ld=%0d: got %0b/%h expected %0b/%h",
                         i, addr, ld, o.err1, o.data1, exp[32], exp[31:0]);
            else pass_cnt++;
            total_cnt++;
            if ({o.err3, o.data3} !== exp)
                $display("FAIL rand%0d data_lat3 addr=%h ld=%0d: got %0b/%h expected %0b/%h",
                         i, addr, ld, o.err3, o.data3, exp[32], exp[31:0]);
            else pass_cnt++;
            total_cnt++;
            if (o.rd1 != rds || o.rd3 != rds)
                $display("FAIL rand%0d strobes: got %0d/%0d expected %0d", i, o.rd1, o.rd3, rds);
            else pass_cnt++;
            total_cnt++;
            if (o.proto_bad)
                $display("FAIL rand%0d protocol: got violation expected none", i);
            else pass_cnt++;
        end
    endtask

    // Consumer stalls: response must hold and no new request may slip in
    task automatic test_stall();
        logic [31:0] held1;
        logic [31:0] held3;
        bit          stable;
        rsp_ready = 1'b0; req_valid = 1'b1; ReqAddr = 32'h12; ldCon = 3'd1;
        @(posedge Clk); #1;
        ReqAddr = 32'h10; ldCon = 3'd0;
        for (int c = 0; c < 3; c++) begin
            @(posedge Clk); #1;
        end
        held1 = rsp_data_1;
        held3 = rsp_data_3;
        total_cnt++;
        if ({rsp_valid_1, rsp_err_1, rsp_data_1} !== {2'b10, 32'hFFFF8081})
            $display("FAIL stall_resp_lat1: got %0b/%0b/%h expected 1/0/ffff8081", rsp_valid_1, rsp_err_1, rsp_data_1);
        else pass_cnt++;
        total_cnt++;
        if ({rsp_valid_3, rsp_err_3, rsp_data_3} !== {2'b10, 32'hFFFF8081})
            $display("FAIL stall_resp_lat3: got %0b/%0b/%h expected 1/0/ffff8081", rsp_valid_3, rsp_err_3, rsp_data_3);
        else pass_cnt++;
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge Clk); #1;
            if (rsp_valid_1 !== 1'b1 || rsp_valid_3 !== 1'b1 || rsp_data_1 !== held1 ||
                rsp_data_3 !== held3 || req_ready_1 !== 1'b0 || req_ready_3 !== 1'b0)
                stable = 1'b0;
        end
        total_cnt++;
        if (!stable)
            $display("FAIL stall_hold: got response changed or ready high expected held");
        else pass_cnt++;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge Clk); #1;
        total_cnt++;
        if ({rsp_valid_1, req_ready_1, rsp_valid_3, req_ready_3} !== 4'b0101)
            $display("FAIL stall_release: got %b expected 0101", {rsp_valid_1, req_ready_1, rsp_valid_3, req_ready_3});
        else pass_cnt++;
    endtask

    // Reset while the latency-3 unit waits on memory; late return is ignored
    task automatic test_reset_mid_op();
        bit   quiet;
        obs_t o;
        rsp_ready = 1'b1; req_valid = 1'b1; ReqAddr = 32'h10; ldCon = 3'd4;
        @(posedge Clk); #1;
        req_valid = 1'b0;
        @(posedge Clk); #1;
        reset = 1'b1;
        @(posedge Clk); #1;
        reset = 1'b0;
        total_cnt++;
        if ({req_ready_1, mem_rd_en_1, mem_addr_1, rsp_valid_1, rsp_data_1, rsp_err_1} !== RESET_VEC)
            $display("FAIL midreset_lat1: got %h expected %h",
                     {req_ready_1, mem_rd_en_1, mem_addr_1, rsp_valid_1, rsp_data_1, rsp_err_1}, RESET_VEC);
        else pass_cnt++;
        total_cnt++;
        if ({req_ready_3, mem_rd_en_3, mem_addr_3, rsp_valid_3, rsp_data_3, rsp_err_3} !== RESET_VEC)
            $display("FAIL midreset_lat3: got %h expected %h",
                     {req_ready_3, mem_rd_en_3, mem_addr_3, rsp_valid_3, rsp_data_3, rsp_err_3}, RESET_VEC);
        else pass_cnt++;
        quiet = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (rsp_valid_1 !== 1'b0 || rsp_valid_3 !== 1'b0 || mem_rd_en_1 !== 1'b0 || mem_rd_en_3 !== 1'b0)
                quiet = 1'b0;
            @(posedge Clk); #1;
        end
        total_cnt++;
        if (!quiet)
            $display("FAIL midreset_quiet: got activity after reset expected none");
        else pass_cnt++;
        run_txn(32'h10, 3'd0, o);
        total_cnt++;
        if (o.first1 != 2 || o.first3 != 4)
            $display("FAIL after_reset latency: got %0d/%0d expected 2/4", o.first1, o.first3);
        else pass_cnt++;
        total_cnt++;
        if ({o.err1, o.data1, o.err3, o.data3} !== {1'b0, 32'h8081F2F3, 1'b0, 32'h8081F2F3})
            $display("FAIL after_reset data: got %h/%h expected 8081f2f3", o.data1, o.data3);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1; ReqAddr = 32'd0; ldCon = 3'd0;
        for (int i = 0; i < 2048; i++) mem[i] = $urandom;
        mem[4] = 32'h8081F2F3;
        test_reset();
        test_loads();
        test_illegal();
        test_random();
        test_stall();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
